// File: rtl/cpu_timer.sv
// cpu_timer: memory-mapped countdown timer on the CPU data bus.
// Software loads PRESET, enables it via CTRL, and the timer counts COUNT down
// to zero, then raises int_flag (and irq when IM is set). MODE=01 auto-reloads,
// every other MODE is one-shot and clears EN when the interrupt fires.
module cpu_timer #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_en;
    logic [1:0]         r_mode;
    logic               r_im;
    logic [WIDTH-1:0]   r_preset;
    logic [WIDTH-1:0]   r_count;
    logic               r_intFlag;

    state_t             w_stateNext;
    logic [WIDTH-1:0]   w_countNext;
    logic               w_enNext;
    logic               w_intFlagNext;
    logic               w_setFlag;
    logic               w_clrFlag;
    logic               w_clrEn;
    logic               w_wrCtrl;
    logic               w_wrPreset;
    logic               w_countZero;
    logic               w_autoReload;
    logic               w_unusedWdata;

    assign w_wrCtrl      = we && (addr == 2'd0);
    assign w_wrPreset    = we && (addr == 2'd1);
    assign w_countZero   = (r_count == '0);
    assign w_autoReload  = (r_mode == 2'b01);
    assign w_unusedWdata = ^wdata;

    // Next-state logic: FSM transitions, counter update, and the EN/flag merge
    // where a CPU write always wins over what the FSM wants on the same edge.
    always_comb begin
        w_stateNext   = r_state;
        w_countNext   = r_count;
        w_setFlag     = 1'b0;
        w_clrFlag     = 1'b0;
        w_clrEn       = 1'b0;
        w_enNext      = r_en;
        w_intFlagNext = r_intFlag;

        case (r_state)
            IDLE: begin
                if (r_en) begin
                    w_stateNext = LOAD;
                end
            end
            LOAD: begin
                w_countNext = r_preset;
                w_stateNext = CNT;
            end
            CNT: begin
                if (!r_en) begin
                    w_stateNext = IDLE;
                end else if (w_countZero) begin
                    w_stateNext = INT;
                    w_setFlag   = 1'b1;
                    w_clrEn     = !w_autoReload;
                end else begin
                    w_countNext = r_count - WIDTH'(1);
                end
            end
            INT: begin
                if (w_autoReload) begin
                    w_stateNext = LOAD;
                    w_clrFlag   = 1'b1;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        if (w_wrCtrl) begin
            w_enNext = wdata[0];
        end else if (w_clrEn) begin
            w_enNext = 1'b0;
        end

        if (w_wrCtrl || w_wrPreset) begin
            w_intFlagNext = 1'b0;
        end else if (w_setFlag) begin
            w_intFlagNext = 1'b1;
        end else if (w_clrFlag) begin
            w_intFlagNext = 1'b0;
        end
    end

    // State and register file update; reset aborts any count in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_en      <= 1'b0;
            r_mode    <= 2'b00;
            r_im      <= 1'b0;
            r_preset  <= '0;
            r_count   <= '0;
            r_intFlag <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_count   <= w_countNext;
            r_en      <= w_enNext;
            r_intFlag <= w_intFlagNext;
            if (w_wrCtrl) begin
                r_mode <= wdata[2:1];
                r_im   <= wdata[3];
            end
            if (w_wrPreset) begin
                r_preset <= wdata[WIDTH-1:0];
            end
        end
    end

    // Read mux straight off the registers so loads see values with no latency.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, r_im, r_mode, r_en};
            2'd1:    rdata = 32'(r_preset);
            2'd2:    rdata = 32'(r_count);
            default: rdata = 32'd0;
        endcase
    end

    assign irq = r_im & r_intFlag;

endmodule

// File: tb/tb_cpu_timer.sv
// tb_cpu_timer: directed self-checking bench for cpu_timer.
module tb_cpu_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    cpu_timer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIrq(input string tag, input logic expected);
        checkOutput(tag, {31'd0, irq}, {31'd0, expected});
    endtask

    task automatic checkReg(input string tag, input logic [1:0] a, input logic [31:0] expected);
        addr = a;
        #1;
        checkOutput(tag, rdata, expected);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    // Directed sequence; every write edge below is called t0 of its scenario.
    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        step(3);
        reset = 1'b0;
        checkReg("rst_ctrl", 2'd0, 32'd0);
        checkReg("rst_preset", 2'd1, 32'd0);
        checkReg("rst_count", 2'd2, 32'd0);
        checkIrq("rst_irq", 1'b0);
        step(1);

        applyStimulus(2'd1, 32'h1234_5678);
        checkReg("preset_readback", 2'd1, 32'h1234_5678);
        applyStimulus(2'd2, 32'hFFFF_FFFF);
        applyStimulus(2'd3, 32'hDEAD_BEEF);
        checkReg("count_write_ignored", 2'd2, 32'd0);
        checkReg("preset_unchanged", 2'd1, 32'h1234_5678);
        checkReg("addr3_reads_zero", 2'd3, 32'd0);
        step(1);
        checkReg("ctrl_unchanged", 2'd0, 32'd0);

        $display("[TB] one-shot PRESET=3 CTRL=0x9");
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'h9);
        step(1);
        checkReg("os_load_t1", 2'd2, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checkReg($sformatf("os_count_t%0d", i + 2), 2'd2, 32'(3 - i));
            checkIrq($sformatf("os_irq_low_t%0d", i + 2), 1'b0);
        end
        step(1);
        checkIrq("os_irq_t6", 1'b1);
        checkReg("os_ctrl_en_cleared", 2'd0, 32'h8);
        step(4);
        checkIrq("os_irq_t10", 1'b1);
        checkReg("os_count_t10", 2'd2, 32'd0);
        applyStimulus(2'd0, 32'h0);
        checkIrq("os_irq_cleared", 1'b0);
        checkReg("os_ctrl_zero", 2'd0, 32'd0);

        $display("[TB] auto-reload PRESET=3 CTRL=0xB");
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'hB);
        for (int c = 1; c <= 20; c++) begin
            step(1);
            checkIrq($sformatf("ar_irq_t%0d", c), (c >= 6) && ((c % 6) == 0));
            if ((c % 6) == 2) begin
                checkReg($sformatf("ar_reload_t%0d", c), 2'd2, 32'd3);
            end
        end
        checkReg("ar_ctrl_kept", 2'd0, 32'hB);
        applyStimulus(2'd0, 32'h0);
        step(2);

        $display("[TB] masked PRESET=2 CTRL=0x1");
        applyStimulus(2'd1, 32'd2);
        applyStimulus(2'd0, 32'h1);
        for (int c = 1; c <= 6; c++) begin
            step(1);
            checkIrq($sformatf("mask_irq_t%0d", c), 1'b0);
        end
        checkReg("mask_ctrl_en_cleared", 2'd0, 32'd0);
        applyStimulus(2'd0, 32'h8);
        checkIrq("mask_write_clears_flag", 1'b0);
        step(2);
        checkIrq("mask_irq_stays_low", 1'b0);
        checkReg("mask_ctrl_im", 2'd0, 32'h8);

        $display("[TB] pause and PRESET update");
        applyStimulus(2'd1, 32'd10);
        applyStimulus(2'd0, 32'h1);
        step(6);
        checkReg("pause_count_t6", 2'd2, 32'd6);
        applyStimulus(2'd0, 32'h0);
        checkReg("pause_count_edge", 2'd2, 32'd5);
        step(3);
        checkReg("pause_count_hold", 2'd2, 32'd5);
        checkReg("pause_ctrl", 2'd0, 32'd0);
        applyStimulus(2'd1, 32'd7);
        applyStimulus(2'd0, 32'h1);
        step(1);
        checkReg("reload_load_cycle", 2'd2, 32'd5);
        step(1);
        checkReg("reload_new_preset", 2'd2, 32'd7);
        applyStimulus(2'd1, 32'd1);
        checkReg("preset_write_midcount", 2'd2, 32'd6);
        checkReg("preset_new_value", 2'd1, 32'd1);
        step(1);
        applyStimulus(2'd0, 32'h0);
        step(2);

        $display("[TB] collision of CTRL write with INT entry");
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'h9);
        step(5);
        checkReg("col_count_t5", 2'd2, 32'd0);
        applyStimulus(2'd0, 32'h9);
        checkIrq("col_irq_t6", 1'b0);
        checkReg("col_ctrl_en_kept", 2'd0, 32'h9);
        step(1);
        checkIrq("col_irq_t7", 1'b0);
        step(1);
        checkReg("col_count_t8", 2'd2, 32'd0);
        step(1);
        checkReg("col_restart_t9", 2'd2, 32'd3);
        step(4);
        checkIrq("col_second_irq_t13", 1'b1);

        $display("[TB] asynchronous reset while irq is high");
        #2;
        reset = 1'b1;
        #1;
        checkIrq("async_rst_irq", 1'b0);
        checkReg("async_rst_ctrl", 2'd0, 32'd0);
        checkReg("async_rst_preset", 2'd1, 32'd0);
        checkReg("async_rst_count", 2'd2, 32'd0);
        step(2);
        reset = 1'b0;
        step(2);
        checkIrq("post_rst_irq", 1'b0);
        checkReg("post_rst_count", 2'd2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
